// File: rtl/mem_pkg.sv
// mem_pkg: shared types for the memory-response stage.
//   load_op_e  - load kind carried from EX (LD_NONE for non-loads)
//   EXC_*      - exception codes carried alongside an instruction
//   is_load()  - true for any load kind
package mem_pkg;

   typedef enum logic [2:0] {
      LD_NONE = 3'd0,
      LD_LB   = 3'd1,
      LD_LBU  = 3'd2,
      LD_LH   = 3'd3,
      LD_LHU  = 3'd4,
      LD_LW   = 3'd5,
      LD_LWL  = 3'd6,
      LD_LWR  = 3'd7
   } load_op_e;

   localparam logic [4:0] EXC_INT  = 5'h00;
   localparam logic [4:0] EXC_ADEL = 5'h04;
   localparam logic [4:0] EXC_ADES = 5'h05;
   localparam logic [4:0] EXC_SYS  = 5'h08;
   localparam logic [4:0] EXC_BP   = 5'h09;
   localparam logic [4:0] EXC_RI   = 5'h0a;
   localparam logic [4:0] EXC_OV   = 5'h0c;

   function automatic logic is_load(input load_op_e op);
      return op != LD_NONE;
   endfunction

endpackage

// File: rtl/load_align.sv
// load_align: combinational load-data alignment.
//   op     in  3   load kind (load_op_e encoding)
//   addr   in  2   low address bits of the load
//   word   in  32  raw memory word (or ALU result for non-loads)
//   gr_we  in  1   instruction writes a GPR
//   result out 32  aligned / extended value
//   strb   out 4   per-byte GPR write enable
import mem_pkg::*;

module load_align (
   input  logic [2:0]  op,
   input  logic [1:0]  addr,
   input  logic [31:0] word,
   input  logic        gr_we,
   output logic [31:0] result,
   output logic [3:0]  strb
);

   logic [7:0]  word_bytes [4];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   load_op_e    op_e;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_bytes
         assign word_bytes[gi] = word[8*gi +: 8];
      end
   endgenerate

   assign op_e     = load_op_e'(op);
   assign byte_sel = word_bytes[addr];
   assign half_sel = addr[1] ? word[31:16] : word[15:0];

   always_comb begin
      result = word;
      strb   = {4{gr_we}};
      case (op_e)
         LD_LB:  result = {{24{byte_sel[7]}}, byte_sel};
         LD_LBU: result = {24'h0, byte_sel};
         LD_LH:  result = {{16{half_sel[15]}}, half_sel};
         LD_LHU: result = {16'h0, half_sel};
         LD_LW:  result = word;
         // Unaligned-left: the addressed bytes land in the top of the register.
         LD_LWL: begin
            case (addr)
               2'd0: begin result = {word[7:0], 24'h0};  strb = 4'b1000; end
               2'd1: begin result = {word[15:0], 16'h0}; strb = 4'b1100; end
               2'd2: begin result = {word[23:0], 8'h0};  strb = 4'b1110; end
               default: begin result = word;             strb = 4'b1111; end
            endcase
         end
         // Unaligned-right: the addressed bytes land in the bottom of the register.
         LD_LWR: begin
            case (addr)
               2'd0: begin result = word;                 strb = 4'b1111; end
               2'd1: begin result = {8'h0, word[31:8]};   strb = 4'b0111; end
               2'd2: begin result = {16'h0, word[31:16]}; strb = 4'b0011; end
               default: begin result = {24'h0, word[31:24]}; strb = 4'b0001; end
            endcase
         end
         default: result = word;
      endcase
   end

endmodule

// File: rtl/mem_resp_stage.sv
// mem_resp_stage: EX->WB pipeline stage that waits for a load's data_ok.
//   Holds one instruction; a load leaves in its data_ok cycle when WB can
//   accept, otherwise the response is buffered. Responses owed to loads
//   cancelled by a flush are counted and discarded.
// Ports:
//   clk, resetn                   clock, async active-low reset
//   es_* / es_to_ms_valid         instruction from EX; ms_allowin back-pressure
//   es_req_owed, flush            flush and in-flight request accounting
//   data_sram_data_ok/rdata       in-order read responses
//   ws_allowin / ms_to_ws_valid   handshake to WB; ms_* result fields
//   ms_fwd_*                      bypass bytes and stall hint for consumers
import mem_pkg::*;

module mem_resp_stage #(
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        es_to_ms_valid,
   output logic        ms_allowin,
   input  logic [31:0] es_pc,
   input  logic [31:0] es_result,
   input  logic [4:0]  es_dest,
   input  logic        es_gr_we,
   input  logic [2:0]  es_load_op,
   input  logic        es_req_issued,
   input  logic        es_ex,
   input  logic [4:0]  es_excode,
   input  logic        es_req_owed,
   input  logic        flush,
   input  logic        data_sram_data_ok,
   input  logic [31:0] data_sram_rdata,
   input  logic        ws_allowin,
   output logic        ms_to_ws_valid,
   output logic [31:0] ms_pc,
   output logic [31:0] ms_result,
   output logic [4:0]  ms_dest,
   output logic [3:0]  ms_gr_strb,
   output logic        ms_ex,
   output logic [4:0]  ms_excode,
   output logic [3:0]  ms_fwd_valid,
   output logic [4:0]  ms_fwd_dest,
   output logic [31:0] ms_fwd_data,
   output logic        ms_fwd_pending
);

   localparam int             DW       = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [DW:0]    DROP_MAX = (DW+1)'(MAX_OUTSTANDING);

   logic          ms_valid_reg,  ms_valid_next;
   logic          waiting_reg,   waiting_next;
   logic          have_data_reg, have_data_next;
   logic [31:0]   data_buf_reg,  data_buf_next;
   logic [DW-1:0] drop_cnt_reg,  drop_cnt_next;
   logic [31:0]   pc_reg, result_reg;
   logic [4:0]    dest_reg, excode_reg;
   logic          gr_we_reg, ex_reg;
   logic [2:0]    load_op_reg;

   logic          drop_consume, own_resp, ms_ready_go, ms_leave, accept;
   logic          ld_active;
   logic [31:0]   load_data, align_word;
   logic [DW:0]   drop_sum;

   // Oldest response goes to the drop counter first, then to the held load.
   assign drop_consume = data_sram_data_ok && (drop_cnt_reg != '0);
   assign own_resp     = data_sram_data_ok && (drop_cnt_reg == '0) && ms_valid_reg && waiting_reg;

   assign ms_ready_go  = !waiting_reg || ((drop_cnt_reg == '0) && data_sram_data_ok);
   assign ms_allowin   = !ms_valid_reg || (ms_ready_go && ws_allowin);
   assign ms_leave     = ms_valid_reg && ms_ready_go && ws_allowin;
   assign accept       = es_to_ms_valid && ms_allowin && !flush;

   assign ms_to_ws_valid = ms_valid_reg && ms_ready_go && !flush;

   always_comb begin
      ms_valid_next  = ms_valid_reg;
      waiting_next   = waiting_reg;
      have_data_next = have_data_reg;
      data_buf_next  = data_buf_reg;
      if (own_resp) begin
         waiting_next = 1'b0;
         // Leaving now uses the bypass; only a stalled load needs the copy.
         if (!ms_leave) begin
            have_data_next = 1'b1;
            data_buf_next  = data_sram_rdata;
         end
      end
      if (ms_leave) ms_valid_next = 1'b0;
      if (accept) begin
         ms_valid_next  = 1'b1;
         waiting_next   = es_req_issued && !es_ex;
         have_data_next = 1'b0;
      end
      if (flush) begin
         ms_valid_next  = 1'b0;
         waiting_next   = 1'b0;
         have_data_next = 1'b0;
      end
   end

   // A flushed load still owed a response, plus a request stranded in EX,
   // both turn into responses that must be thrown away later.
   always_comb begin
      drop_sum = {1'b0, drop_cnt_reg} - {{DW{1'b0}}, drop_consume};
      if (flush) begin
         drop_sum = drop_sum + {{DW{1'b0}}, waiting_reg && !own_resp}
                             + {{DW{1'b0}}, es_req_owed};
      end
      if (drop_sum > DROP_MAX) drop_cnt_next = DROP_MAX[DW-1:0];
      else                     drop_cnt_next = drop_sum[DW-1:0];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ms_valid_reg  <= 1'b0;
         waiting_reg   <= 1'b0;
         have_data_reg <= 1'b0;
         data_buf_reg  <= '0;
         drop_cnt_reg  <= '0;
         pc_reg        <= '0;
         result_reg    <= '0;
         dest_reg      <= '0;
         gr_we_reg     <= 1'b0;
         load_op_reg   <= LD_NONE;
         ex_reg        <= 1'b0;
         excode_reg    <= '0;
      end else begin
         ms_valid_reg  <= ms_valid_next;
         waiting_reg   <= waiting_next;
         have_data_reg <= have_data_next;
         data_buf_reg  <= data_buf_next;
         drop_cnt_reg  <= drop_cnt_next;
         if (accept) begin
            pc_reg      <= es_pc;
            result_reg  <= es_result;
            dest_reg    <= es_dest;
            gr_we_reg   <= es_gr_we;
            load_op_reg <= es_load_op;
            ex_reg      <= es_ex;
            excode_reg  <= es_excode;
         end
      end
   end

   assign ld_active  = is_load(load_op_e'(load_op_reg));
   assign load_data  = have_data_reg ? data_buf_reg : data_sram_rdata;
   assign align_word = ld_active ? load_data : result_reg;

   load_align u_align (
      .op     (load_op_reg),
      .addr   (result_reg[1:0]),
      .word   (align_word),
      .gr_we  (gr_we_reg),
      .result (ms_result),
      .strb   (ms_gr_strb)
   );

   assign ms_pc          = pc_reg;
   assign ms_dest        = dest_reg;
   assign ms_ex          = ms_valid_reg && ex_reg;
   assign ms_excode      = excode_reg;
   assign ms_fwd_valid   = ms_valid_reg ? ms_gr_strb : 4'b0000;
   assign ms_fwd_dest    = dest_reg;
   assign ms_fwd_data    = ms_result;
   assign ms_fwd_pending = ms_valid_reg && ld_active && !ms_ready_go;

endmodule

// File: tb/tb_mem_resp_stage.sv
module tb_mem_resp_stage;
   import mem_pkg::*;

   logic        clk = 1'b0;
   logic        resetn;
   logic        es_to_ms_valid, ms_allowin;
   logic [31:0] es_pc, es_result;
   logic [4:0]  es_dest, es_excode;
   logic        es_gr_we, es_req_issued, es_ex, es_req_owed, flush;
   logic [2:0]  es_load_op;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   logic        ws_allowin, ms_to_ws_valid;
   logic [31:0] ms_pc, ms_result, ms_fwd_data;
   logic [4:0]  ms_dest, ms_excode, ms_fwd_dest;
   logic [3:0]  ms_gr_strb, ms_fwd_valid;
   logic        ms_ex, ms_fwd_pending;

   always #5 clk = ~clk;

   mem_resp_stage #(.MAX_OUTSTANDING(2)) dut (
      .clk(clk), .resetn(resetn),
      .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
      .es_pc(es_pc), .es_result(es_result), .es_dest(es_dest),
      .es_gr_we(es_gr_we), .es_load_op(es_load_op),
      .es_req_issued(es_req_issued), .es_ex(es_ex), .es_excode(es_excode),
      .es_req_owed(es_req_owed), .flush(flush),
      .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
      .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
      .ms_pc(ms_pc), .ms_result(ms_result), .ms_dest(ms_dest),
      .ms_gr_strb(ms_gr_strb), .ms_ex(ms_ex), .ms_excode(ms_excode),
      .ms_fwd_valid(ms_fwd_valid), .ms_fwd_dest(ms_fwd_dest),
      .ms_fwd_data(ms_fwd_data), .ms_fwd_pending(ms_fwd_pending)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      es_to_ms_valid = 0; es_pc = 0; es_result = 0; es_dest = 0; es_gr_we = 0;
      es_load_op = LD_NONE; es_req_issued = 0; es_ex = 0; es_excode = 0;
      es_req_owed = 0; flush = 0; data_sram_data_ok = 0; data_sram_rdata = 0;
      ws_allowin = 1;
   endtask

   task automatic issue(input load_op_e op, input logic [31:0] pc, input logic [31:0] res);
      es_to_ms_valid = 1; es_pc = pc; es_result = res; es_dest = 5'd9;
      es_gr_we = 1; es_load_op = op; es_req_issued = (op != LD_NONE);
   endtask

   task automatic unissue();
      es_to_ms_valid = 0; es_load_op = LD_NONE; es_req_issued = 0; es_ex = 0;
   endtask

   typedef struct {
      load_op_e    op;
      logic [31:0] res;
      logic        gr_we;
      logic [31:0] rdata;
      logic [31:0] exp_result;
      logic [3:0]  exp_strb;
   } vec_t;

   vec_t vecs[14];

   task automatic run_vec(input int idx, input vec_t v);
      es_to_ms_valid = 1; es_pc = 32'hbfc0_0000 + 32'(idx * 4); es_result = v.res;
      es_dest = 5'(idx + 1); es_gr_we = v.gr_we; es_load_op = v.op;
      es_req_issued = (v.op != LD_NONE); ws_allowin = 1;
      @(negedge clk);
      chk("vec_allowin", 32'(ms_allowin), 32'd1);
      tick();
      unissue();
      data_sram_data_ok = (v.op != LD_NONE);
      data_sram_rdata   = (v.op != LD_NONE) ? v.rdata : 32'h5a5a_5a5a;
      @(negedge clk);
      chk("vec_valid",  32'(ms_to_ws_valid), 32'd1);
      chk("vec_result", ms_result, v.exp_result);
      chk("vec_strb",   32'(ms_gr_strb), 32'(v.exp_strb));
      chk("vec_fwd",    32'(ms_fwd_valid), 32'(v.exp_strb));
      chk("vec_pc",     ms_pc, 32'hbfc0_0000 + 32'(idx * 4));
      $display("vec %0d op=%0d res=%08h rdata=%08h -> result=%08h strb=%b",
               idx, v.op, v.res, v.rdata, ms_result, ms_gr_strb);
      tick();
      data_sram_data_ok = 0;
      @(negedge clk);
      chk("vec_drain", 32'(ms_to_ws_valid), 32'd0);
      tick();
   endtask

   initial begin
      vecs[0]  = '{LD_NONE, 32'h0000_1234, 1'b1, 32'h0,         32'h0000_1234, 4'b1111};
      vecs[1]  = '{LD_NONE, 32'hdead_0000, 1'b0, 32'h0,         32'hdead_0000, 4'b0000};
      vecs[2]  = '{LD_LB,   32'h1000_0001, 1'b1, 32'h0000_80ff, 32'hffff_ff80, 4'b1111};
      vecs[3]  = '{LD_LBU,  32'h1000_0003, 1'b1, 32'h9a00_0000, 32'h0000_009a, 4'b1111};
      vecs[4]  = '{LD_LB,   32'h1000_0000, 1'b1, 32'h1234_567f, 32'h0000_007f, 4'b1111};
      vecs[5]  = '{LD_LH,   32'h1000_0002, 1'b1, 32'h8001_1234, 32'hffff_8001, 4'b1111};
      vecs[6]  = '{LD_LHU,  32'h1000_0000, 1'b1, 32'h1234_f00d, 32'h0000_f00d, 4'b1111};
      vecs[7]  = '{LD_LW,   32'h1000_0000, 1'b1, 32'hcafe_babe, 32'hcafe_babe, 4'b1111};
      vecs[8]  = '{LD_LWL,  32'h1000_0000, 1'b1, 32'h1122_3344, 32'h4400_0000, 4'b1000};
      vecs[9]  = '{LD_LWL,  32'h1000_0001, 1'b1, 32'h1122_3344, 32'h3344_0000, 4'b1100};
      vecs[10] = '{LD_LWL,  32'h1000_0003, 1'b1, 32'h1122_3344, 32'h1122_3344, 4'b1111};
      vecs[11] = '{LD_LWR,  32'h1000_0000, 1'b1, 32'h1122_3344, 32'h1122_3344, 4'b1111};
      vecs[12] = '{LD_LWR,  32'h1000_0001, 1'b1, 32'h1122_3344, 32'h0011_2233, 4'b0111};
      vecs[13] = '{LD_LWR,  32'h1000_0003, 1'b1, 32'h1122_3344, 32'h0000_0011, 4'b0001};

      // Reset state
      idle();
      resetn = 0;
      #12;
      chk("rst_allowin", 32'(ms_allowin), 32'd1);
      chk("rst_valid",   32'(ms_to_ws_valid), 32'd0);
      chk("rst_result",  ms_result, 32'd0);
      chk("rst_strb",    32'(ms_gr_strb), 32'd0);
      chk("rst_pending", 32'(ms_fwd_pending), 32'd0);
      chk("rst_ex",      32'(ms_ex), 32'd0);
      $display("reset state checked");
      tick();
      resetn = 1;
      tick();

      for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

      // LB with data_ok two cycles late: consumers stall until the bypass cycle
      issue(LD_LB, 32'h0000_0100, 32'h2000_0001);
      tick(); unissue();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("lb_pending", 32'(ms_fwd_pending), 32'd1);
         chk("lb_hold",    32'(ms_to_ws_valid), 32'd0);
         tick();
      end
      data_sram_data_ok = 1; data_sram_rdata = 32'h0000_80ff;
      @(negedge clk);
      chk("lb_valid",   32'(ms_to_ws_valid), 32'd1);
      chk("lb_result",  ms_result, 32'hffff_ff80);
      chk("lb_nopend",  32'(ms_fwd_pending), 32'd0);
      $display("late LB result=%08h", ms_result);
      tick(); data_sram_data_ok = 0;

      // LWR with WB stalled: buffered data survives junk on rdata
      issue(LD_LWR, 32'h0000_0104, 32'h2000_0002);
      ws_allowin = 0;
      tick(); unissue();
      data_sram_data_ok = 1; data_sram_rdata = 32'haabb_ccdd;
      @(negedge clk);
      chk("lwr_present", 32'(ms_to_ws_valid), 32'd1);
      chk("lwr_bypass",  ms_result, 32'h0000_aabb);
      tick();
      data_sram_data_ok = 0; data_sram_rdata = 32'hffff_ffff;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("lwr_buf",     ms_result, 32'h0000_aabb);
         chk("lwr_blocked", 32'(ms_allowin), 32'd0);
         tick();
      end
      ws_allowin = 1;
      @(negedge clk);
      chk("lwr_release", ms_result, 32'h0000_aabb);
      chk("lwr_strb",    32'(ms_gr_strb), 32'b0011);
      chk("lwr_allowin", 32'(ms_allowin), 32'd1);
      $display("buffered LWR result=%08h strb=%b", ms_result, ms_gr_strb);
      tick();
      @(negedge clk);
      chk("lwr_gone", 32'(ms_to_ws_valid), 32'd0);
      tick();

      // Exception passes without waiting for data, ms_ex gated by valid
      issue(LD_LW, 32'h0000_0108, 32'h2000_0000);
      es_ex = 1; es_excode = EXC_ADEL;
      tick(); unissue(); es_excode = 0;
      @(negedge clk);
      chk("ex_valid",   32'(ms_to_ws_valid), 32'd1);
      chk("ex_flag",    32'(ms_ex), 32'd1);
      chk("ex_code",    32'(ms_excode), 32'(EXC_ADEL));
      chk("ex_nopend",  32'(ms_fwd_pending), 32'd0);
      tick();
      @(negedge clk);
      chk("ex_gated",   32'(ms_ex), 32'd0);
      $display("exception passthrough excode=%0h", EXC_ADEL);
      tick();

      // Flush a waiting load (with EX also valid): one response dropped
      issue(LD_LW, 32'h0000_0200, 32'h3000_0000);
      tick();
      issue(LD_NONE, 32'h0000_0204, 32'h0000_0777);
      flush = 1;
      @(negedge clk);
      chk("fl_gate", 32'(ms_to_ws_valid), 32'd0);
      tick(); flush = 0; unissue();
      @(negedge clk);
      chk("fl_noacc", 32'(ms_to_ws_valid), 32'd0);
      tick();
      issue(LD_LW, 32'h0000_0208, 32'h3000_0004);
      tick(); unissue();
      data_sram_data_ok = 1; data_sram_rdata = 32'h1;
      @(negedge clk);
      chk("fl_drop",    32'(ms_to_ws_valid), 32'd0);
      chk("fl_pending", 32'(ms_fwd_pending), 32'd1);
      tick();
      data_sram_rdata = 32'h2;
      @(negedge clk);
      chk("fl_valid",  32'(ms_to_ws_valid), 32'd1);
      chk("fl_result", ms_result, 32'h2);
      tick(); data_sram_data_ok = 0;
      issue(LD_LW, 32'h0000_020c, 32'h3000_0008);
      tick(); unissue();
      data_sram_data_ok = 1; data_sram_rdata = 32'h3;
      @(negedge clk);
      chk("fl_clear", ms_result, 32'h3);
      chk("fl_clear_v", 32'(ms_to_ws_valid), 32'd1);
      $display("flush drop-one sequence result=%08h", ms_result);
      tick(); data_sram_data_ok = 0;

      // Flush with waiting load and owed request: two responses dropped
      issue(LD_LW, 32'h0000_0300, 32'h3000_0010);
      tick(); unissue();
      flush = 1; es_req_owed = 1;
      tick(); flush = 0; es_req_owed = 0;
      issue(LD_LW, 32'h0000_0304, 32'h3000_0014);
      tick(); unissue();
      data_sram_data_ok = 1;
      for (int c = 0; c < 2; c++) begin
         data_sram_rdata = 32'h11 * 32'(c + 1);
         @(negedge clk);
         chk("owed_drop", 32'(ms_to_ws_valid), 32'd0);
         tick();
      end
      data_sram_rdata = 32'h33;
      @(negedge clk);
      chk("owed_valid",  32'(ms_to_ws_valid), 32'd1);
      chk("owed_result", ms_result, 32'h33);
      $display("flush drop-two sequence result=%08h", ms_result);
      tick(); data_sram_data_ok = 0;

      // Flush coinciding with data_ok: response belongs to the flushed load
      issue(LD_LW, 32'h0000_0400, 32'h3000_0020);
      tick(); unissue();
      flush = 1; data_sram_data_ok = 1; data_sram_rdata = 32'hbad0;
      tick(); flush = 0; data_sram_data_ok = 0;
      issue(LD_LW, 32'h0000_0404, 32'h3000_0024);
      tick(); unissue();
      data_sram_data_ok = 1; data_sram_rdata = 32'h44;
      @(negedge clk);
      chk("fl_ok_valid",  32'(ms_to_ws_valid), 32'd1);
      chk("fl_ok_result", ms_result, 32'h44);
      $display("flush with data_ok result=%08h", ms_result);
      tick(); data_sram_data_ok = 0;

      // Reset while waiting: outputs clear immediately
      issue(LD_LW, 32'h1234_5678, 32'h3000_0030);
      tick(); unissue();
      @(negedge clk);
      chk("mr_pending", 32'(ms_fwd_pending), 32'd1);
      #1 resetn = 0;
      #1;
      chk("mr_allowin", 32'(ms_allowin), 32'd1);
      chk("mr_valid",   32'(ms_to_ws_valid), 32'd0);
      chk("mr_pc",      ms_pc, 32'd0);
      chk("mr_pending0", 32'(ms_fwd_pending), 32'd0);
      chk("mr_fwd",     32'(ms_fwd_valid), 32'd0);
      tick(); resetn = 1;
      tick();
      issue(LD_LW, 32'h0000_0500, 32'h3000_0040);
      tick(); unissue();
      data_sram_data_ok = 1; data_sram_rdata = 32'h55;
      @(negedge clk);
      chk("mr_after", ms_result, 32'h55);
      chk("mr_after_v", 32'(ms_to_ws_valid), 32'd1);
      $display("reset mid-wait sequence result=%08h", ms_result);
      tick(); data_sram_data_ok = 0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
